mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares one single-ported, variable-latency unified memory between the instruction-fetch port (read-only) and the data-memory port (read/write) of the pipelined CPU.
- Grants one requester at a time and drives the memory handshake.
- Returns read data and per-port acknowledge and stall signals; the hazard logic uses the stalls to freeze PC, IF/ID and later stages.
- Data port has priority; a streak counter prevents instruction-fetch starvation.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  DATA_W  registered fetch data; holds until next fetch completes.
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle pulse; read data valid, or write committed.
- d_rdata  out  DATA_W  registered read data; unchanged by writes.
- d_stall  out  1  d_req & ~d_ack.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle; may arrive the first cycle mem_req is high.
- busy  out  1  state != IDLE.

## Operation
FSM states: IDLE, BUSY_I, BUSY_D, DONE.

**IDLE**
- Arbitrate each cycle.
- If d_req and not (if_req and streak == MAX_DSTREAK):
  - grant data; latch d_addr/d_we/d_wdata into mem_* registers.
  - go to BUSY_D.
- Else if if_req:
  - grant fetch; latch if_addr; mem_we = 0.
  - go to BUSY_I.
- mem_ack while in IDLE is ignored.

**streak counter**
- On a data grant with if_req high: streak increments, saturating at MAX_DSTREAK.
- On a data grant with if_req low: streak = 0.
- On a fetch grant: streak = 0.

**BUSY_I / BUSY_D**
- mem_req = 1; mem_addr, mem_we and mem_wdata stay stable (registered).
- Requester input changes after the grant are ignored.
- On mem_ack:
  - read: capture mem_rdata into the granted port's rdata register.
  - write: rdata is unchanged.
  - Set the granted port's ack for the next cycle; go to DONE.

**DONE**
- Pulse the ack; mem_req = 0; no arbitration.
- Next state is IDLE. This gives the requester one cycle to drop or replace its request.

**Reset**
- All outputs 0; rdata registers 0; streak 0; state IDLE.
- Reset during BUSY aborts the access: mem_req drops the next cycle and no ack is issued.
- A late mem_ack after reset is ignored.

## Timing
- Request seen in IDLE at cycle t.
- mem_req high from t+1.
- mem_ack at cycle k ≥ t+1.
- Port ack and valid rdata at k+1 (DONE).
- IDLE at k+2, where arbitration resumes.
- Minimum latency: 2 cycles from request to ack. Maximum throughput: one access per 3 cycles.
- if_stall and d_stall are combinational from req and ack; all other outputs are registered.
- Simultaneous if_req and d_req: data wins unless streak == MAX_DSTREAK.
- A request arriving while BUSY/DONE waits; its stall stays high.
- mem_we is never 1 during a fetch grant.

## Test plan
- **Single fetch:**
  - Stimulus: if_req, addr 0x40, at t0; memory acks at t1 with 0x8C010004.
  - Required: mem_req t1 only; if_ack and if_rdata = 0x8C010004 at t2; if_stall high t0–t1; busy low at t3.
- **Data write then read:**
  - Stimulus: write 0x1234 to 0x100; then read 0x100 with the memory model echoing it; memory latency 3.
  - Required: mem_we = 1 only on the write; d_ack 4 cycles after each grant; d_rdata = 0x1234; d_rdata unchanged after the write ack.
- **Simultaneous requests:**
  - Stimulus: if_req and d_req both high at t0.
  - Required: data granted first; fetch granted in the IDLE cycle after the data DONE.
- **Starvation guard:**
  - Stimulus: MAX_DSTREAK = 4; d_req continuously high with new accesses; if_req high.
  - Required: exactly 4 data grants, then 1 fetch grant, then data resumes.
- **Reset mid-access:**
  - Stimulus: reset asserted in BUSY_D; mem_ack arrives one cycle after reset releases.
  - Required: mem_req 0 after reset; no d_ack; state IDLE; all outputs 0.
- **Held inputs ignored:**
  - Stimulus: change d_addr from 0x10 to 0x20 while BUSY_D.
  - Required: mem_addr stays 0x10 until DONE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Lets the CPU's instruction-fetch port (read-only) and data port
// (read/write) share one single-ported, variable-latency memory.
// Only one port is granted at a time, and this block drives the memory
// handshake for it. Each port gets back read data, a one-cycle ack and a
// stall flag; the hazard logic uses the stalls to freeze the pipeline.
// The data port has priority. A streak counter limits it to MAX_DSTREAK
// consecutive grants while a fetch is waiting, so fetch cannot starve.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr          fetch request (held until if_ack) and address
//   if_ack/if_rdata         ack pulse and registered fetch data
//   if_stall                if_req & ~if_ack
//   d_req/d_we/d_addr/
//   d_wdata                 data request (held until d_ack), write enable,
//                           address, write data
//   d_ack/d_rdata           ack pulse and registered read data (writes do
//                           not change it)
//   d_stall                 d_req & ~d_ack
//   mem_req/mem_we/
//   mem_addr/mem_wdata      memory request, held until mem_ack
//   mem_rdata/mem_ack       memory read data and completion pulse
//   busy                    arbiter not in IDLE
//
// State | meaning
//   IDLE   | arbitrate between pending requests
//   BUSY_I | fetch access outstanding, waiting for mem_ack
//   BUSY_D | data access outstanding, waiting for mem_ack
//   DONE   | port ack pulses; requester may drop or replace its request
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     streak;
  logic              fetch_urgent;
  logic              grant_d;
  logic              grant_i;

  logic              if_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;

  // A pending fetch that has already waited out MAX_DSTREAK data grants
  // takes precedence over the data port.
  always_comb begin
    state_nxt    = state;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    fetch_urgent = if_req && (streak == STREAK_MAX);
    case (state)
      IDLE: begin
        if (d_req && !fetch_urgent) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      streak      <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      busy_q   <= (state_nxt != IDLE);

      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        // The streak only counts grants that made a fetch wait.
        if (if_req) begin
          if (streak != STREAK_MAX) streak <= streak + SW'(1);
        end else begin
          streak <= '0;
        end
      end else if (grant_i) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= if_addr;
        streak     <= '0;
      end

      // mem_ack outside BUSY_I/BUSY_D (e.g. a late ack after reset) is ignored.
      if (mem_ack && (state == BUSY_I)) begin
        mem_req_q  <= 1'b0;
        if_ack_q   <= 1'b1;
        if_rdata_q <= mem_rdata;
      end

      if (mem_ack && (state == BUSY_D)) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        d_ack_q   <= 1'b1;
        if (!mem_we_q) d_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule
